// File: rtl/accu_pkg.sv
// Shared definitions for the multi-channel window accumulator:
// result/counter width helpers and the error-flag encoding.
package accu_pkg;

  // Error flag encoding for err_ch
  localparam logic ERR_CLEAR  = 1'b0;  // no out-of-range channel seen
  localparam logic ERR_BAD_CH = 1'b1;  // a sample arrived with in_ch >= NUM_CH

  // Width of a full-window sum: a window of win_len samples of din_w bits
  // can never overflow this, with one extra bit of margin for the sign.
  function automatic int accu_out_w(input int din_w, input int win_len);
    return din_w + $clog2(win_len) + 1;
  endfunction

  // Width of the per-channel sample counter (counts 0 .. win_len-1)
  function automatic int cnt_w(input int win_len);
    return $clog2(win_len);
  endfunction

endpackage

// File: rtl/accu_lane.sv
// One channel of the window accumulator: a running sum and sample counter.
// done pulses combinationally on the add that completes a window; sum_done
// carries the completed window sum in that same cycle, and the lane
// restarts from zero on the next edge.
module accu_lane
  import accu_pkg::*;
#(
  parameter int SUM_W   = 39,
  parameter int WIN_LEN = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic signed [SUM_W-1:0] din_ext,
  output logic                    done,
  output logic signed [SUM_W-1:0] sum_done
);

  localparam int               CNT_W    = cnt_w(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Next sum/count: clear has priority, a completing add restarts the window
  always_comb begin
    done     = add_en && !clr && (cnt_q == CNT_LAST);
    sum_done = sum_q + din_ext;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    if (clr) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (done) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (add_en) begin
      sum_d = sum_done;
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/win_accu_mc.sv
// Multi-channel tumbling-window accumulator.
// Time-interleaved signed samples tagged with a channel index are summed
// per channel; every WIN_LEN accepted samples on a channel one window sum
// is emitted through a single-entry output register.
// Optional build macro WIN_ACCU_ABS_EN: accumulate |din| instead of din.
module win_accu_mc
  import accu_pkg::*;
#(
  parameter  int DIN_W   = 32,
  parameter  int WIN_LEN = 50,
  parameter  int NUM_CH  = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DOUT_W  = accu_out_w(DIN_W, WIN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DIN_W-1:0]  din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     err_ch
);

  // Handshake: a transfer happens on any edge where valid && ready on that
  // side. The output is a single register whose ready passes straight
  // through to the input (in_ready = !out_valid || out_ready), so a stalled
  // result freezes all channel state and nothing is ever dropped. in_valid
  // never reaches out_valid combinationally.

  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic signed [DOUT_W-1:0] dout_q, dout_d;
  logic                     err_ch_q, err_ch_d;

  logic                     accept;
  logic                     ch_ok;
  logic signed [DOUT_W-1:0] din_ext;
  logic [NUM_CH-1:0]        add_en;
  logic [NUM_CH-1:0]        lane_done;
  logic signed [DOUT_W-1:0] lane_sum [NUM_CH];
  logic                     done_any;
  logic [CH_W-1:0]          done_ch;
  logic signed [DOUT_W-1:0] done_sum;

  assign in_ready = !out_valid_q || out_ready;

  // Sample contribution, widened to the result width
`ifdef WIN_ACCU_ABS_EN
  logic signed [DIN_W:0] din_wide;
  logic signed [DIN_W:0] din_abs;

  // Magnitude in DIN_W+1 bits so the most-negative input stays exact
  always_comb begin
    din_wide = (DIN_W + 1)'(din);
    din_abs  = din_wide[DIN_W] ? -din_wide : din_wide;
    din_ext  = DOUT_W'(din_abs);
  end
`else
  // Plain sign extension of the sample
  always_comb begin
    din_ext = DOUT_W'(din);
  end
`endif

  // Channel decode: one lane at most is enabled; clr suppresses the add
  always_comb begin
    accept = in_valid && in_ready;
    ch_ok  = 32'(in_ch) < 32'(NUM_CH);
    add_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      add_en[c] = accept && !clr && ch_ok && (in_ch == CH_W'(c));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    accu_lane #(
      .SUM_W   (DOUT_W),
      .WIN_LEN (WIN_LEN)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .add_en   (add_en[g]),
      .din_ext  (din_ext),
      .done     (lane_done[g]),
      .sum_done (lane_sum[g])
    );
  end

  // Select the completing lane (at most one per cycle)
  always_comb begin
    done_any = |lane_done;
    done_ch  = '0;
    done_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (lane_done[c]) begin
        done_ch  = CH_W'(c);
        done_sum = lane_sum[c];
      end
    end
  end

  // Output register next state and sticky channel error
  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    dout_d      = dout_q;
    err_ch_d    = err_ch_q;
    if (done_any) begin
      out_valid_d = 1'b1;
      out_ch_d    = done_ch;
      dout_d      = done_sum;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && !ch_ok) begin
      err_ch_d = ERR_BAD_CH;
    end
  end

  // Output and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      dout_q      <= '0;
      err_ch_q    <= ERR_CLEAR;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      dout_q      <= dout_d;
      err_ch_q    <= err_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign dout      = dout_q;
  assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_win_accu_mc.sv
// Bench for win_accu_mc: instance A (DIN_W=8, WIN_LEN=4, NUM_CH=5) covers
// interleaving, back-pressure, clr, rst, out-of-range channels and random
// traffic; instance B (DIN_W=32, WIN_LEN=50, NUM_CH=1) covers the long window.
module tb_win_accu_mc;

  localparam int DIN_W  = 8;
  localparam int WIN    = 4;
  localparam int NCH    = 5;
  localparam int CHW    = 3;
  localparam int DOUTW  = 11;
  localparam int B_WIN  = 50;
  localparam int B_DOUTW = 39;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic                    clr = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b1;
  logic [CHW-1:0]          in_ch = '0;
  logic signed [DIN_W-1:0] din = '0;
  logic                    in_ready, out_valid, err_ch;
  logic [CHW-1:0]          out_ch;
  logic signed [DOUTW-1:0] dout;

  win_accu_mc #(.DIN_W(DIN_W), .WIN_LEN(WIN), .NUM_CH(NCH)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .dout(dout), .err_ch(err_ch)
  );

  // ---------------- instance B ----------------
  logic                      clr_b = 1'b0;
  logic                      in_valid_b = 1'b0;
  logic                      out_ready_b = 1'b1;
  logic [0:0]                in_ch_b = '0;
  logic signed [31:0]        din_b = 32'sd1;
  logic                      in_ready_b, out_valid_b, err_ch_b;
  logic [0:0]                out_ch_b;
  logic signed [B_DOUTW-1:0] dout_b;

  win_accu_mc #(.DIN_W(32), .WIN_LEN(B_WIN), .NUM_CH(1)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ch(in_ch_b), .din(din_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_ch(out_ch_b), .dout(dout_b), .err_ch(err_ch_b)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint contrib(input logic signed [DIN_W-1:0] d);
`ifdef WIN_ACCU_ABS_EN
    return (d < 0) ? -longint'(d) : longint'(d);
`else
    return longint'(d);
`endif
  endfunction

  // ---------------- scoreboard A ----------------
  logic [CHW+DOUTW-1:0] exp_q[$];
  longint               m_sum[NCH];
  int                   m_cnt[NCH];
  logic                 m_err = 1'b0;

  always @(negedge clk) begin
    logic                 exp_rdy;
    logic [CHW+DOUTW-1:0] f;
    int                   c;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
      m_err = 1'b0;
    end else begin
      exp_rdy = (exp_q.size() == 0) || out_ready;
      check_eq("out_valid", longint'(out_valid), longint'(exp_q.size() != 0));
      check_eq("in_ready", longint'(in_ready), longint'(exp_rdy));
      check_eq("err_ch", longint'(err_ch), longint'(m_err));
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        check_eq("dout", longint'(dout), longint'($signed(f[DOUTW-1:0])));
        check_eq("out_ch", longint'(out_ch), longint'(f[DOUTW +: CHW]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        c = int'(in_ch);
        if (c >= NCH) begin
          m_err = 1'b1;
        end else if (!clr) begin
          m_sum[c] += contrib(din);
          m_cnt[c]++;
          if (m_cnt[c] == WIN) begin
            exp_q.push_back({CHW'(c), DOUTW'(m_sum[c])});
            m_sum[c] = 0;
            m_cnt[c] = 0;
          end
        end
      end
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
      end
    end
  end

  // ---------------- scoreboard B ----------------
  logic [B_DOUTW-1:0] exp_b_q[$];
  longint             mb_sum = 0;
  int                 mb_cnt = 0;
  logic               mb_err = 1'b0;
  int                 nb_res = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_b_q.delete();
      mb_sum = 0;
      mb_cnt = 0;
      mb_err = 1'b0;
    end else begin
      check_eq("b_out_valid", longint'(out_valid_b), longint'(exp_b_q.size() != 0));
      check_eq("b_in_ready", longint'(in_ready_b), 1);
      check_eq("b_err_ch", longint'(err_ch_b), longint'(mb_err));
      if (exp_b_q.size() != 0) begin
        check_eq("b_dout", longint'(dout_b), longint'($signed(exp_b_q[0])));
        check_eq("b_out_ch", longint'(out_ch_b), 0);
        void'(exp_b_q.pop_front());
        nb_res++;
      end
      if (in_valid_b) begin
        if (in_ch_b != 1'b0) begin
          mb_err = 1'b1;
        end else begin
          mb_sum += longint'(din_b);
          mb_cnt++;
          if (mb_cnt == B_WIN) begin
            exp_b_q.push_back(B_DOUTW'(mb_sum));
            mb_sum = 0;
            mb_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded)
  task automatic send(input int ch, input int d);
    int  n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_ch    = ch[CHW-1:0];
    din      = d[DIN_W-1:0];
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  logic rand_done = 1'b0;

  // ---------------- main sequence ----------------
  initial begin
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_dout", longint'(dout), 0);
    check_eq("rst_out_ch", longint'(out_ch), 0);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_err_ch", longint'(err_ch), 0);
    check_eq("rst_b_dout", longint'(dout_b), 0);
    idle(1);

    // round-robin channels 0..3, din = ch+1
    for (int w = 0; w < WIN; w++)
      for (int c = 0; c < 4; c++) send(c, c + 1);
    idle(3);

    // most-negative input, full window
    repeat (WIN) send(2, -128);
    idle(3);

    // back-pressure with a second completion waiting for out_ready
    repeat (WIN - 1) send(0, 1);
    repeat (WIN - 1) send(1, 3);
    out_ready = 1'b0;
    send(0, 1);
    fork
      send(1, 3);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    // clr mid-window; the sample in the clr cycle is ignored
    repeat (WIN - 1) send(0, 2);
    clr = 1'b1; in_valid = 1'b1; in_ch = 3'd0; din = 8'sd2;
    idle(1);
    clr = 1'b0; in_valid = 1'b0;
    repeat (WIN) send(0, 2);
    idle(3);

    // rst mid-window discards the partial sum
    repeat (WIN - 1) send(3, 5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    repeat (WIN) send(3, 2);
    idle(3);

    // out-of-range channel: dropped, sticky flag, others unaffected
    repeat (WIN - 1) send(1, 7);
    send(5, 100);
    send(1, 7);
    idle(2);
    check_eq("err_sticky", longint'(err_ch), 1);
    clr = 1'b1; idle(1); clr = 1'b0;
    idle(2);
    check_eq("err_after_clr", longint'(err_ch), 1);

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 80; i++) send(int'($urandom_range(0, 4)), int'($urandom_range(0, 255)) - 128);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check_eq("drain_a", longint'(exp_q.size()), 0);

    // long window on instance B: din=1 for 100 samples
    in_valid_b = 1'b1;
    idle(2 * B_WIN);
    in_valid_b = 1'b0;
    idle(3);
    check_eq("b_results", longint'(nb_res), 2);
    check_eq("drain_b", longint'(exp_b_q.size()), 0);
    in_ch_b = 1'b1; in_valid_b = 1'b1;
    idle(1);
    in_valid_b = 1'b0; in_ch_b = 1'b0;
    idle(2);
    check_eq("b_err_set", longint'(err_ch_b), 1);

    // rst clears the sticky flags
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("err_cleared", longint'(err_ch), 0);
    check_eq("b_err_cleared", longint'(err_ch_b), 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/win_accu_mc.md
Name: win_accu_mc

Overview:
- Multi-channel tumbling-window accumulator; next generation of the single-channel 50-sample accumulator.
- Accepts time-interleaved signed samples tagged with a channel index, keeps an independent running sum and sample counter per channel, and emits one window sum per channel every WIN_LEN accepted samples.
- Sits between the feature-extraction datapath and the result FIFO.
- Uses valid/ready on both sides so back-pressure from the FIFO stalls the input instead of dropping data.

Parameters:
- DIN_W, 32, signed input sample width.
- WIN_LEN, 50, samples per window per channel; legal range 2..1024.
- NUM_CH, 4, number of independent channels; legal range 1..64.
- CH_W, $clog2(NUM_CH) with a minimum of 1, channel index width (derived, not overridden).
- DOUT_W, DIN_W+$clog2(WIN_LEN)+1, result width (derived); a full window can never overflow.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous, active-high reset.
- clr, in, 1, synchronous clear of all channel sums and counters; no output is produced.
- in_valid, in, 1, sample present.
- in_ready, out, 1, block can accept a sample this cycle.
- in_ch, in, CH_W, channel of the sample.
- din, in, DIN_W, signed sample.
- out_valid, out, 1, window result present.
- out_ready, in, 1, downstream accepts the result.
- out_ch, out, CH_W, channel of the result.
- dout, out, DOUT_W, signed window sum.
- err_ch, out, 1, sticky flag: a sample arrived with in_ch >= NUM_CH.

Behaviour:
- Reset: every per-channel sum and counter = 0; out_valid = 0; out_ch = 0; dout = 0; err_ch = 0. Reset asserted mid-window discards all partial sums.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single-entry output register with pass-through ready; there is no combinational path from in_valid to out_valid.
- On accept with c = in_ch < NUM_CH:
  - If cnt[c] < WIN_LEN-1: sum[c] <= sum[c] + sext(din); cnt[c] <= cnt[c]+1.
  - If cnt[c] == WIN_LEN-1 (window completes): dout <= sum[c] + sext(din); out_ch <= c; out_valid <= 1; sum[c] <= 0; cnt[c] <= 0.
  - Latency is 1 cycle from the completing sample to out_valid.
- On accept with in_ch >= NUM_CH: the sample is dropped, no channel state changes, and err_ch <= 1. err_ch clears only on rst.
- Output handshake:
  - out_valid && out_ready with no new completion: out_valid <= 0 next cycle.
  - out_valid && out_ready with a simultaneous completion: the new result loads and out_valid stays 1.
  - out_valid && !out_ready: dout and out_ch hold, in_ready = 0, and all channel state holds.
- clr:
  - Zeroes all sum and cnt values in the same cycle.
  - An accept in the same cycle is ignored. clr wins, but err_ch is still set if in_ch is out of range.
  - A pending output (out_valid) is not affected by clr.
- Arithmetic: two's complement. Inputs are sign-extended to DOUT_W before adding. No saturation is needed because of the DOUT_W sizing.
- Channels are fully independent; any interleaving order, including back-to-back samples on the same channel, is legal.

Optional Feature:
- Macro: WIN_ACCU_ABS_EN.
- Defined: each accepted sample contributes |din| instead of din (line-length/energy style feature).
  - |most-negative| is computed in DIN_W+1 bits, so it is exact.
  - dout is still declared signed but is always >= 0.
- Undefined: signed accumulation exactly as above; no abs logic is present.

Decomposition:
- Package accu_pkg holds:
  - function accu_out_w(din_w, win_len), returning the DOUT_W formula.
  - function cnt_w(win_len), returning $clog2(win_len).
  - Shared error-flag encoding constants.
- Sub-module accu_lane holds one channel's sum and counter:
  - Inputs: add_en, clr, din_ext.
  - Outputs: done pulse and the completed sum.
- win_accu_mc instantiates NUM_CH accu_lane in a generate loop and adds the channel decode, the output register and the handshake logic.

Test Plan:
- NUM_CH=1, WIN_LEN=50, din=1 for 100 cycles, out_ready=1 -> two results, dout=50, out_ch=0, each appearing 1 cycle after samples 50 and 100.
- NUM_CH=4, WIN_LEN=4, round-robin channels 0..3 with din = ch+1 -> ch0..ch3 results 4, 8, 12, 16 on consecutive cycles, in order.
- DIN_W=8, WIN_LEN=4, din=-128 x4 -> dout=-512 (no overflow). With WIN_ACCU_ABS_EN defined -> dout=+512.
- ch0 window completes while out_ready=0 for 5 cycles -> in_ready=0 for those cycles, no samples lost; a second completion arriving in the same cycle out_ready rises loads immediately.
- ch0 has 3 of 4 samples when clr pulses (or rst) -> no output; the next 4 samples of din=2 give dout=8.
- in_ch=5 with NUM_CH=4 -> sample dropped, err_ch=1 sticky until rst, other channels unaffected.
